// File: rtl/conv_layer_sequencer.sv
// Purpose : control sequencer for the conv2 channel-parallel MAC datapath; walks
//           every output pixel of a KxK valid convolution, one kernel tap per cycle.
// Latency : first tap the cycle after start; result strobe PIPE_LAT enabled cycles after a last tap.
// Backpr. : stall=1 in RUN/DRAIN drops all enables and freezes counters, addresses and delay line.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   stall         buffer/consumer not ready
//   ena_conv      enable for multiplier, adder tree, bias, ReLU and rescale stages
//   ena_adder     enable for the tap accumulator
//   acc_first     tap 0 of a pixel (accumulator loads instead of adds)
//   rd_addr       feature address (out_row+tap_row)*IN_W + out_col+tap_col
//   wt_addr       weight tap index tap_row*K + tap_col
//   wr_valid      datapath result valid this cycle
//   wr_addr       output pixel index, row-major
//   busy, done    busy in RUN/DRAIN/DONE; done pulses for one cycle at end of map
//   perf_cycles, perf_stalls   only when CONV_LAYER_SEQUENCER_PERF_EN is defined
module conv_layer_sequencer #(
   parameter int IN_W     = 12,
   parameter int IN_H     = 12,
   parameter int K        = 5,
   parameter int PIPE_LAT = 8,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              stall,
   output logic              ena_conv,
   output logic              ena_adder,
   output logic              acc_first,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wt_addr,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done
`ifdef CONV_LAYER_SEQUENCER_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stalls
`endif
);

   localparam int OUT_W = IN_W - K + 1;
   localparam int OUT_H = IN_H - K + 1;
   localparam int TW    = (K > 1) ? $clog2(K) : 1;
   localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int DW    = $clog2(PIPE_LAT + 1);

   localparam logic [TW-1:0]     TAP_LAST   = TW'(K - 1);
   localparam logic [CW-1:0]     COL_LAST   = CW'(OUT_W - 1);
   localparam logic [RW-1:0]     ROW_LAST   = RW'(OUT_H - 1);
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);
   localparam logic [ADDR_W-1:0] A_IN_W     = ADDR_W'(IN_W);
   localparam logic [ADDR_W-1:0] A_K        = ADDR_W'(K);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [TW-1:0]       tap_col, tap_row;
   logic [CW-1:0]       out_col;
   logic [RW-1:0]       out_row;
   logic [ADDR_W-1:0]   pix_base;   // address of tap (0,0) of the current pixel
   logic [ADDR_W-1:0]   row_base;   // address of tap (tap_row,0) of the current pixel
   logic [DW-1:0]       drain_cnt;
   logic [PIPE_LAT-1:0] dly;

   logic tap_last, pix_last, issue_last, launch;

   assign tap_last   = (tap_col == TAP_LAST) && (tap_row == TAP_LAST);
   assign pix_last   = (out_col == COL_LAST) && (out_row == ROW_LAST);
   assign issue_last = (state == S_RUN) && tap_last;
   assign launch     = (state == S_IDLE) && start;

   // A result leaves the datapath only on an enabled cycle, so the strobe is
   // gated by the same enable that advances the delay line.
   assign wr_valid   = dly[PIPE_LAT-1] && ena_conv;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ena_conv  = 1'b0;
      ena_adder = 1'b0;
      acc_first = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            ena_conv  = !stall;
            ena_adder = !stall;
            acc_first = !stall && (tap_col == '0) && (tap_row == '0);
            if (!stall && tap_last && pix_last) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy     = 1'b1;
            ena_conv = !stall;
            if (!stall && (drain_cnt == DRAIN_LAST)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Tap/pixel walk. Addresses are built incrementally: +1 along a kernel row,
   // +IN_W to the next kernel row, and a pixel step re-bases from pix_base
   // (+1 along an output row, +K to wrap from the last column to the next row).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tap_col   <= '0;
         tap_row   <= '0;
         out_col   <= '0;
         out_row   <= '0;
         pix_base  <= '0;
         row_base  <= '0;
         rd_addr   <= '0;
         wt_addr   <= '0;
         drain_cnt <= '0;
         dly       <= '0;
         wr_addr   <= '0;
      end else if (launch) begin
         tap_col   <= '0;
         tap_row   <= '0;
         out_col   <= '0;
         out_row   <= '0;
         pix_base  <= '0;
         row_base  <= '0;
         rd_addr   <= '0;
         wt_addr   <= '0;
         drain_cnt <= '0;
         dly       <= '0;
         wr_addr   <= '0;
      end else begin
         if ((state == S_RUN) && !stall) begin
            if (!tap_last) begin
               wt_addr <= wt_addr + 1'b1;
               if (tap_col != TAP_LAST) begin
                  tap_col <= tap_col + 1'b1;
                  rd_addr <= rd_addr + 1'b1;
               end else begin
                  tap_col  <= '0;
                  tap_row  <= tap_row + 1'b1;
                  row_base <= row_base + A_IN_W;
                  rd_addr  <= row_base + A_IN_W;
               end
            end else begin
               tap_col <= '0;
               tap_row <= '0;
               wt_addr <= '0;
               if (out_col != COL_LAST) begin
                  out_col  <= out_col + 1'b1;
                  pix_base <= pix_base + 1'b1;
                  row_base <= pix_base + 1'b1;
                  rd_addr  <= pix_base + 1'b1;
               end else if (!pix_last) begin
                  out_col  <= '0;
                  out_row  <= out_row + 1'b1;
                  pix_base <= pix_base + A_K;
                  row_base <= pix_base + A_K;
                  rd_addr  <= pix_base + A_K;
               end else begin
                  out_col  <= '0;
                  out_row  <= '0;
                  pix_base <= '0;
                  row_base <= '0;
                  rd_addr  <= '0;
               end
            end
         end
         if ((state == S_DRAIN) && !stall) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
         if (ena_conv) begin
            dly <= {dly[PIPE_LAT-2:0], issue_last};
         end
         if (wr_valid) begin
            wr_addr <= wr_addr + 1'b1;
         end
      end
   end

`ifdef CONV_LAYER_SEQUENCER_PERF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if (launch) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy) begin
            perf_cycles <= perf_cycles + 1'b1;
         end
         if (((state == S_RUN) || (state == S_DRAIN)) && stall) begin
            perf_stalls <= perf_stalls + 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Control FSM that drives the conv2 channel-parallel MAC datapath: enables, per-tap read address, and result write strobes.
- Walks every output pixel of a KxK valid convolution over an IN_W x IN_H map, presenting one kernel tap (all CHANNEL lanes at once) per cycle.
- Tracks datapath latency with an enable-gated delay line, so wr_valid lines up with each finished rescaled result.
- Sits between the feature/weight buffers and the conv datapath; one start per feature map.

Parameters:
- IN_W, 12, input map width
- IN_H, 12, input map height
- K, 5, kernel size; OUT_W=IN_W-K+1, OUT_H=IN_H-K+1
- PIPE_LAT, 8, enabled cycles from a last-tap cycle to its result at the datapath output
- ADDR_W, 8, width of rd_addr/wr_addr/wt_addr

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- stall  in  1  buffer/consumer not ready; freezes sequencing
- ena_conv  out  1  enable for multiplier, adder tree, bias, ReLU and rescale stages
- ena_adder  out  1  enable for the tap accumulator
- acc_first  out  1  tap 0 of a pixel; accumulator loads instead of adds
- rd_addr  out  ADDR_W  feature address (out_row+tap_row)*IN_W+out_col+tap_col
- wt_addr  out  ADDR_W  weight tap index tap_row*K+tap_col
- wr_valid  out  1  result_conv2 is valid this cycle
- wr_addr  out  ADDR_W  output pixel index, row-major, 0..OUT_W*OUT_H-1
- busy  out  1  high in RUN, DRAIN and DONE
- done  out  1  one-cycle pulse at end of map

Behaviour:
- Reset (async, rstn=0): state IDLE; all counters, delay line, wr_addr and outputs go to 0.
- States:
  - IDLE: start=1 -> RUN; other inputs ignored.
  - RUN: one tap per unstalled cycle. tap_col increments first, then tap_row. After tap (K-1,K-1): out_col increments, then out_row. When the last tap of the last pixel issues -> DRAIN.
  - DRAIN: flushes PIPE_LAT unstalled cycles, then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Cycle counts:
  - First RUN cycle is the cycle after start is sampled.
  - Unstalled RUN = OUT_W*OUT_H*K*K cycles.
- RUN outputs, stall=0:
  - ena_conv=1, ena_adder=1.
  - acc_first=1 only on tap (0,0).
  - rd_addr and wt_addr are registered and valid in the same cycle as the enables.
- DRAIN outputs, stall=0: ena_conv=1, ena_adder=0, acc_first=0.
- stall=1 in RUN or DRAIN:
  - ena_conv, ena_adder, acc_first and wr_valid forced to 0.
  - All counters, addresses and the delay line hold.
  - Stall in IDLE or DONE has no effect.
- Delay line:
  - PIPE_LAT-bit shift register, advances only when ena_conv=1.
  - Input bit is 1 on each last-tap cycle.
  - wr_valid = output bit AND ena_conv.
  - wr_addr increments after each wr_valid; it clears on start.
- Latency: a last-tap cycle t with no later stalls gives wr_valid at t+PIPE_LAT. The final wr_valid falls in the last DRAIN cycle.
- start while busy is ignored; no queueing.
- Address arithmetic:
  - Computed incrementally by adders, no multipliers.
  - ADDR_W must hold IN_W*IN_H-1; out-of-range configuration is not supported.
- Reset asserted mid-run: immediate return to IDLE, no done pulse. Partial results are discarded by the consumer.

Optional Feature:
- Macro: CONV_LAYER_SEQUENCER_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] (cycles spent busy) and perf_stalls[31:0] (RUN/DRAIN cycles with stall=1).
  - Both clear on start and hold after done.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Defaults, start at cycle 0, no stall:
  - ena_conv high cycles 1..1608; ena_adder high cycles 1..1600.
  - acc_first pulses 64 times, at cycles 1, 26, 51, ...
  - wr_valid 64 times, first at cycle 33, last at 1608 with wr_addr=63.
  - done at cycle 1609.
- Address walk, pixel 0: rd_addr sequence 0,1,2,3,4,12,13,...,52; wt_addr 0..24. Pixel 9 (row1,col1) tap 0: rd_addr=13.
- stall=1 for 5 cycles mid-RUN:
  - enables low and counters frozen during the stall.
  - done moves to cycle 1614; all 64 wr_valid still present with unchanged wr_addr order.
- stall during DRAIN at the final wr_valid cycle: wr_valid withheld until stall drops, then exactly one pulse with wr_addr=63.
- start re-pulsed at cycle 100 of RUN: ignored, total still 64 results. rstn=0 at cycle 500: all outputs 0 asynchronously, no done. A new start after reset runs the full map.
- CONV_LAYER_SEQUENCER_PERF_EN defined, 5-cycle stall: perf_cycles=1614, perf_stalls=5 after done.
